// File: rtl/stack_sequencer.sv
// Command-level controller for one operand stack: expands WebAssembly-style stack
// commands into single-cycle PUSH/POP/REPLACE micro-ops and rejects illegal ones early.
module stack_sequencer #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = 3,
  parameter int DW        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [1:0]       rsp_error,
  output logic [WIDTH-1:0] rsp_data,
  output logic [DW-1:0]    depth,
  output logic [1:0]       stack_op,
  output logic [WIDTH-1:0] stack_data,
  input  logic [WIDTH-1:0] stack_tos,
  input  logic [1:0]       stack_status
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_ADD  = 3'd5;
  localparam logic [2:0] OP_SUB  = 3'd6;
  localparam logic [2:0] OP_EQZ  = 3'd7;

  // Micro-op and status encodings of the attached stack (stack.vh)
  localparam logic [1:0] SOP_NONE      = 2'd0;
  localparam logic [1:0] SOP_PUSH      = 2'd1;
  localparam logic [1:0] SOP_POP       = 2'd2;
  localparam logic [1:0] SOP_REPLACE   = 2'd3;
  localparam logic [1:0] STS_UNDERFLOW = 2'd2;
  localparam logic [1:0] STS_OVERFLOW  = 2'd3;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_FAULT = 2'd3;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EX1,
    S_EX2,
    S_EX3,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] t0_q;
  logic [WIDTH-1:0] t1_q;
  logic [DW-1:0]    depth_q;
  logic [1:0]       err_q;
  logic             fault_q;

  logic [1:0]       precheckErr;
  logic [DW-1:0]    depthDelta;
  logic             faultNow;
  logic             accept;

  assign accept   = cmd_valid && (state_q == S_IDLE);
  assign faultNow = (stack_status == STS_UNDERFLOW) || (stack_status == STS_OVERFLOW);
  assign depth    = depth_q;

  always_comb begin
    precheckErr = ERR_OK;
    case (cmd_op)
      OP_PUSH: if (depth_q == DEPTH_MAX) precheckErr = ERR_OVER;
      OP_DUP: begin
        if (depth_q == '0)             precheckErr = ERR_UNDER;
        else if (depth_q == DEPTH_MAX) precheckErr = ERR_OVER;
      end
      OP_DROP, OP_EQZ:        if (depth_q == '0)        precheckErr = ERR_UNDER;
      OP_SWAP, OP_ADD, OP_SUB: if (depth_q <= DEPTH_ONE) precheckErr = ERR_UNDER;
      default: precheckErr = ERR_OK;
    endcase
  end

  always_comb begin
    depthDelta = '0;
    case (op_q)
      OP_PUSH, OP_DUP:         depthDelta = DEPTH_ONE;
      OP_DROP, OP_ADD, OP_SUB: depthDelta = '1;
      default:                 depthDelta = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (precheckErr != ERR_OK || cmd_op == OP_NOP) state_d = S_RESP;
          else                                           state_d = S_EX1;
        end
      end
      S_EX1:   state_d = (op_q inside {OP_ADD, OP_SUB, OP_SWAP}) ? S_EX2 : S_RESP;
      S_EX2:   state_d = (op_q == OP_SWAP) ? S_EX3 : S_RESP;
      S_EX3:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Faults seen in EX1 belong to an earlier command, so only later states are sampled
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_NOP;
      data_q  <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      depth_q <= '0;
      err_q   <= ERR_OK;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q    <= cmd_op;
            data_q  <= cmd_data;
            err_q   <= precheckErr;
            fault_q <= 1'b0;
          end
        end
        S_EX1: t0_q <= stack_tos;
        S_EX2: begin
          t1_q <= stack_tos;
          if (faultNow) fault_q <= 1'b1;
        end
        S_EX3: if (faultNow) fault_q <= 1'b1;
        S_RESP: if (err_q == ERR_OK) depth_q <= depth_q + depthDelta;
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    rsp_valid  = (state_q == S_RESP) && !reset;
    rsp_error  = ERR_OK;
    rsp_data   = '0;
    stack_op   = SOP_NONE;
    stack_data = '0;
    case (state_q)
      S_EX1: begin
        case (op_q)
          OP_PUSH: begin
            stack_op   = SOP_PUSH;
            stack_data = data_q;
          end
          OP_DUP: begin
            stack_op   = SOP_PUSH;
            stack_data = stack_tos;
          end
          OP_EQZ: begin
            stack_op   = SOP_REPLACE;
            stack_data = {{(WIDTH-1){1'b0}}, (stack_tos == '0)};
          end
          OP_DROP, OP_ADD, OP_SUB, OP_SWAP: stack_op = SOP_POP;
          default: stack_op = SOP_NONE;
        endcase
      end
      S_EX2: begin
        stack_op = SOP_REPLACE;
        case (op_q)
          OP_ADD:  stack_data = stack_tos + t0_q;
          OP_SUB:  stack_data = stack_tos - t0_q;
          default: stack_data = t0_q;
        endcase
      end
      S_EX3: begin
        stack_op   = SOP_PUSH;
        stack_data = t1_q;
      end
      S_RESP: begin
        rsp_error = (fault_q || faultNow) ? ERR_FAULT : err_q;
        rsp_data  = stack_tos;
      end
      default: ;
    endcase
    // The stack shares this reset, so nothing may be issued to it while reset is high
    if (reset) begin
      stack_op   = SOP_NONE;
      stack_data = '0;
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a behavioural 3-entry stack attached;
// one task per scenario, each comparing against hand-computed values.
module tb_stack_sequencer;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [1:0] rsp_error;
  logic [7:0] rsp_data;
  logic [1:0] depth;
  logic [1:0] stack_op;
  logic [7:0] stack_data;
  logic [7:0] stack_tos;
  logic [1:0] stack_status;

  logic [7:0] mdlMem [0:2];
  int         mdlCount;
  logic [1:0] mdlStatus;
  logic       injectFault;

  int total;
  int bad;

  stack_sequencer #(.WIDTH(8), .MAX_DEPTH(3), .DW(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data), .depth(depth),
    .stack_op(stack_op), .stack_data(stack_data),
    .stack_tos(stack_tos), .stack_status(stack_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: 0 ok, 2 underflow, 3 overflow
  always @(posedge clk) begin
    if (reset) begin
      mdlCount  <= 0;
      mdlStatus <= 2'd0;
    end else begin
      mdlStatus <= 2'd0;
      case (stack_op)
        2'd1: if (mdlCount == 3) mdlStatus <= 2'd3;
              else begin mdlMem[mdlCount] <= stack_data; mdlCount <= mdlCount + 1; end
        2'd2: if (mdlCount == 0) mdlStatus <= 2'd2;
              else mdlCount <= mdlCount - 1;
        2'd3: if (mdlCount == 0) mdlStatus <= 2'd2;
              else mdlMem[mdlCount-1] <= stack_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    stack_tos    = (mdlCount > 0) ? mdlMem[mdlCount-1] : 8'h00;
    stack_status = injectFault ? 2'd2 : mdlStatus;
  end

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic doCmd(input logic [2:0] op, input logic [7:0] d,
                       output logic [1:0] err, output logic [7:0] rd,
                       output int lat, output logic sawOp);
    err = 2'd0; rd = 8'h00; sawOp = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      if (stack_op !== 2'd0) sawOp = 1'b1;
      @(posedge clk);
      #1 lat++;
    end
    if (!rsp_valid) begin
      total++; bad++;
      $display("[TB] FAIL rsp_timeout: op=%0d no rsp_valid within %0d cycles", op, lat);
    end else begin
      err = rsp_error;
      rd  = rsp_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", cmd_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rspvalid: got %b want 0", rsp_valid); end
    total++; if (stack_op !== 2'd0) begin bad++; $display("[TB] FAIL reset_stackop: got %0d want 0", stack_op); end
    total++; if (stack_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_stackdata: got %h want 00", stack_data); end
    total++; if (rsp_error !== 2'd0) begin bad++; $display("[TB] FAIL reset_err: got %0d want 0", rsp_error); end
    @(posedge clk);
    #1 reset = 1'b0;
    total++; if (depth !== 2'd0) begin bad++; $display("[TB] FAIL reset_depth: got %0d want 0", depth); end
  endtask

  task automatic test_drop_underflow();
    logic [1:0] e; logic [7:0] r; int l; logic s;
    doCmd(3'd2, 8'h00, e, r, l, s);
    total++; if (e !== 2'd1) begin bad++; $display("[TB] FAIL drop_empty_err: got %0d want 1", e); end
    total++; if (l !== 1) begin bad++; $display("[TB] FAIL drop_empty_lat: got %0d want 1", l); end
    total++; if (depth !== 2'd0) begin bad++; $display("[TB] FAIL drop_empty_depth: got %0d want 0", depth); end
    total++; if (s !== 1'b0) begin bad++; $display("[TB] FAIL drop_empty_noop: saw stack_op %b want 0", s); end
  endtask

  task automatic test_add_sub();
    logic [1:0] e; logic [7:0] r; int l; logic s;
    doCmd(3'd1, 8'h05, e, r, l, s);
    total++; if (l !== 2) begin bad++; $display("[TB] FAIL push_lat: got %0d want 2", l); end
    doCmd(3'd1, 8'h03, e, r, l, s);
    doCmd(3'd5, 8'h00, e, r, l, s);
    total++; if (l !== 3) begin bad++; $display("[TB] FAIL add_lat: got %0d want 3", l); end
    total++; if (r !== 8'h08) begin bad++; $display("[TB] FAIL add_data: got %h want 08", r); end
    total++; if (e !== 2'd0) begin bad++; $display("[TB] FAIL add_err: got %0d want 0", e); end
    total++; if (depth !== 2'd1) begin bad++; $display("[TB] FAIL add_depth: got %0d want 1", depth); end
    doCmd(3'd2, 8'h00, e, r, l, s);
    doCmd(3'd1, 8'h03, e, r, l, s);
    doCmd(3'd1, 8'h05, e, r, l, s);
    doCmd(3'd6, 8'h00, e, r, l, s);
    total++; if (r !== 8'hFE) begin bad++; $display("[TB] FAIL sub_wrap: got %h want fe", r); end
    doCmd(3'd2, 8'h00, e, r, l, s);
    total++; if (depth !== 2'd0) begin bad++; $display("[TB] FAIL sub_cleanup_depth: got %0d want 0", depth); end
  endtask

  task automatic test_eqz_dup_nop();
    logic [1:0] e; logic [7:0] r; int l; logic s;
    doCmd(3'd1, 8'h00, e, r, l, s);
    doCmd(3'd7, 8'h00, e, r, l, s);
    total++; if (r !== 8'h01) begin bad++; $display("[TB] FAIL eqz_zero: got %h want 01", r); end
    total++; if (l !== 2) begin bad++; $display("[TB] FAIL eqz_lat: got %0d want 2", l); end
    doCmd(3'd7, 8'h00, e, r, l, s);
    total++; if (r !== 8'h00) begin bad++; $display("[TB] FAIL eqz_nonzero: got %h want 00", r); end
    doCmd(3'd3, 8'h00, e, r, l, s);
    total++; if (r !== 8'h00 || depth !== 2'd2) begin bad++; $display("[TB] FAIL dup: got data %h depth %0d want 00 depth 2", r, depth); end
    doCmd(3'd0, 8'h00, e, r, l, s);
    total++; if (l !== 1 || e !== 2'd0 || depth !== 2'd2) begin bad++; $display("[TB] FAIL nop: got lat %0d err %0d depth %0d want 1 0 2", l, e, depth); end
    doCmd(3'd2, 8'h00, e, r, l, s);
    doCmd(3'd2, 8'h00, e, r, l, s);
  endtask

  task automatic test_swap();
    logic [1:0] e; logic [7:0] r; int l; logic s;
    doCmd(3'd1, 8'h01, e, r, l, s);
    doCmd(3'd1, 8'h02, e, r, l, s);
    doCmd(3'd4, 8'h00, e, r, l, s);
    total++; if (r !== 8'h01) begin bad++; $display("[TB] FAIL swap_data: got %h want 01", r); end
    total++; if (l !== 4) begin bad++; $display("[TB] FAIL swap_lat: got %0d want 4", l); end
    total++; if (depth !== 2'd2) begin bad++; $display("[TB] FAIL swap_depth: got %0d want 2", depth); end
    doCmd(3'd2, 8'h00, e, r, l, s);
    total++; if (r !== 8'h02) begin bad++; $display("[TB] FAIL swap_drop: got %h want 02", r); end
    doCmd(3'd2, 8'h00, e, r, l, s);
  endtask

  task automatic test_overflow();
    logic [1:0] e; logic [7:0] r; int l; logic s;
    doCmd(3'd1, 8'h07, e, r, l, s);
    doCmd(3'd1, 8'h08, e, r, l, s);
    doCmd(3'd1, 8'h09, e, r, l, s);
    total++; if (depth !== 2'd3) begin bad++; $display("[TB] FAIL full_depth: got %0d want 3", depth); end
    doCmd(3'd1, 8'h04, e, r, l, s);
    total++; if (e !== 2'd2) begin bad++; $display("[TB] FAIL push_full_err: got %0d want 2", e); end
    total++; if (r !== 8'h09 || depth !== 2'd3) begin bad++; $display("[TB] FAIL push_full_state: got tos %h depth %0d want 09 3", r, depth); end
    doCmd(3'd3, 8'h00, e, r, l, s);
    total++; if (e !== 2'd2) begin bad++; $display("[TB] FAIL dup_full_err: got %0d want 2", e); end
    doCmd(3'd4, 8'h00, e, r, l, s);
    total++; if (e !== 2'd0 || r !== 8'h08) begin bad++; $display("[TB] FAIL swap_full: got err %0d data %h want 0 08", e, r); end
    doCmd(3'd2, 8'h00, e, r, l, s);
    total++; if (r !== 8'h09) begin bad++; $display("[TB] FAIL swap_full_next: got %h want 09", r); end
  endtask

  task automatic test_fault();
    logic [1:0] e; logic [7:0] r; int l; logic s;
    doReset();
    injectFault = 1'b1;
    doCmd(3'd1, 8'h04, e, r, l, s);
    injectFault = 1'b0;
    total++; if (e !== 2'd3) begin bad++; $display("[TB] FAIL fault_err: got %0d want 3", e); end
    total++; if (depth !== 2'd1) begin bad++; $display("[TB] FAIL fault_depth: got %0d want 1", depth); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] e; logic [7:0] r; int l; logic s;
    logic sawRsp;
    doReset();
    doCmd(3'd1, 8'h01, e, r, l, s);
    doCmd(3'd1, 8'h02, e, r, l, s);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 8'h00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++; if (stack_op !== 2'd0) begin bad++; $display("[TB] FAIL midreset_stackop: got %0d want 0", stack_op); end
    sawRsp = rsp_valid;
    repeat (3) begin
      @(posedge clk);
      #1 if (rsp_valid) sawRsp = 1'b1;
    end
    reset = 1'b0;
    total++; if (sawRsp !== 1'b0) begin bad++; $display("[TB] FAIL midreset_rsp: got %b want 0", sawRsp); end
    total++; if (cmd_ready !== 1'b1 || depth !== 2'd0) begin bad++; $display("[TB] FAIL midreset_idle: got ready %b depth %0d want 1 0", cmd_ready, depth); end
    doCmd(3'd2, 8'h00, e, r, l, s);
    total++; if (e !== 2'd1) begin bad++; $display("[TB] FAIL midreset_drop: got %0d want 1", e); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00; injectFault = 1'b0;
    test_reset();
    test_drop_underflow();
    test_add_sub();
    test_eqz_dup_nop();
    test_swap();
    test_overflow();
    test_fault();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
